controle_multiciclo: RTL and testbench
======================================

Name: controle_multiciclo

Overview:
- Control unit for the multicycle processor datapath: R0..R7, A, G, IR, and a single shared 16-bit bus fed from R0..R7, G or DIN.
- Sequences each instruction through time steps T0..T3. Generates the bus-source selects, register load enables, AddSub and Done.
- Sits between the IR/G-flag outputs of the datapath and its mux/enable inputs.

Parameters:
- N_REGS, 8, number of general registers; must equal 2**REG_BITS.
- REG_BITS, 3, width of the Rx/Ry fields.
- OP_BITS, 3, width of the opcode field.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Resetn  in  1  reset, synchronous and active-low.
- Run  in  1  start request, sampled only in T0.
- IR  in  9  instruction register contents: [8:6] opcode, [5:3] Rx, [2:0] Ry.
- G_nz  in  1  1 when the datapath G register is nonzero.
- IRin  out  1  load IR from DIN[8:0].
- DINout  out  1  drive DIN onto the bus.
- Gout  out  1  drive G onto the bus.
- Rout  out  8  one-hot: drive R[i] onto the bus.
- Rin  out  8  one-hot: load R[i] from the bus.
- Ain  out  1  load A from the bus.
- Gin  out  1  load G from the ALU result.
- AddSub  out  1  ALU operation: 0 = A+bus, 1 = A-bus.
- Done  out  1  final step of the current instruction.
- Tstep  out  2  current time step, 0..3.

Behaviour:
- State is the 2-bit Tstep register only.
- All control outputs are combinational decodes of (Tstep, IR, Run, G_nz). No output registers.
- Reset: Resetn=0 at a rising edge sets Tstep=0. This also applies mid-instruction; the partial instruction is abandoned.
- In T0 after reset, every output is 0 except IRin, which equals Run.
- Unless stated, every enable is 0 in every step.
- At most one of DINout, Gout and the Rout bits is 1 in any cycle. When none is, the bus value is a don't-care.
- Opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 100 mvnz; 101..111 illegal.
- T0 (fetch):
  - IRin=Run.
  - Run=0: hold T0, no enables.
  - Run=1: next Tstep=1.
- mv: T1 Rout[Ry]=1, Rin[Rx]=1, Done=1. Next T0.
- mvi: T1 DINout=1, Rin[Rx]=1, Done=1. Next T0. The immediate is the DIN word present during T1.
- add/sub:
  - T1: Rout[Rx]=1, Ain=1.
  - T2: Rout[Ry]=1, Gin=1, AddSub=0 for add, 1 for sub.
  - T3: Gout=1, Rin[Rx]=1, Done=1. Next T0.
  - Rx=Ry is legal and produces 2*Rx or 0.
- mvnz: T1 Rout[Ry]=1, Rin[Rx]=G_nz, Done=1 regardless of G_nz. Next T0.
- Illegal opcode: T1 Done=1, no enables (acts as NOP). Next T0.
- Latency in cycles including fetch: mv, mvi, mvnz, illegal = 2; add, sub = 4.
- Back-to-back instructions: with Run held at 1, the cycle after Done is T0 and fetches again, with no idle cycle.
- Run is ignored in T1..T3; dropping Run mid-instruction does not abort it.
- Tstep=3 is reachable only for add/sub. If Tstep=3 with any other opcode (e.g. IR was forced), assert Done only, and next Tstep=0.

Optional Feature:
- Macro: CTRL_INSTR_COUNT_EN.
- Defined:
  - Adds output instr_count (16 bits): the number of completed instructions, incremented on each rising edge where Done=1, wrapping from 65535 to 0.
  - Cleared to 0 by reset.
  - Illegal-opcode NOPs are counted.
- Undefined: the port and counter are absent; no other behaviour changes.

Decomposition:
- Shared package/include, ctrl_defs:
  - Opcode constants OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_MVNZ.
  - Step constants T0..T3.
  - IR field bit positions.
- Sub-module dec3to8: 3-to-8 one-hot decoder with enable, instantiated for Rx and for Ry.
  - Rin is built from the Rx decode; Rout from the Rx or Ry decode as selected per step.

Test Plan:
- Reset then mv R0,R1 (IR=000_000_001), Run=1 -> T0 IRin=1; T1 Rout=00000010, Rin=00000001, Done=1; then Tstep=0.
- mvi R0 (IR=001_000_001) with DIN=5 in T1 -> T1 DINout=1, Rin=00000001, Done=1, Rout=0.
- sub R1,R0 (IR=011_001_000) ->
  - T1: Rout=00000010, Ain=1.
  - T2: Rout=00000001, Gin=1, AddSub=1.
  - T3: Gout=1, Rin=00000010, Done=1.
  - Total 4 cycles; add variant gives AddSub=0 in T2.
- mvnz R0,R1 (IR=100_000_001) ->
  - G_nz=0: T1 Rout=00000010, Rin=0, Done=1.
  - G_nz=1: T1 Rin=00000001, Done=1.
- Run=0 for 3 cycles after reset -> Tstep stays 0, all outputs 0. Reset asserted during add T2 -> next cycle Tstep=0, Gin=0, Done never pulses.
- With CTRL_INSTR_COUNT_EN: execute mv, sub, then illegal opcode 111 back-to-back -> instr_count=3 after the 8th cycle. Also check Done-to-fetch with no idle cycle.

Source files
------------

// File: rtl/controle_multiciclo_pkg.sv
// Shared definitions for the multicycle control unit:
// opcodes, time-step encoding and IR field positions.
package ctrl_defs;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVNZ = 3'b100;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_e;

  localparam int IR_RY_LSB = 0;
  localparam int IR_RX_LSB = 3;
  localparam int IR_OP_LSB = 6;

endpackage

// File: rtl/controle_multiciclo_dec3to8.sv
// One-hot register decoder with enable.
// Ports: a (index), en, y (one-hot, all zero when en=0).
module dec3to8 #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 8
) (
  input  logic [IN_W-1:0]  a,
  input  logic             en,
  output logic [OUT_W-1:0] y
);

  always_comb begin
    y = '0;
    if (en) y[a] = 1'b1;
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle processor control: sequences T0..T3 and
// decodes bus selects, load enables, AddSub and Done.
// Inputs: Clock, Resetn (sync, active-low), Run, IR, G_nz.
// Outputs: IRin, DINout, Gout, Rout, Rin, Ain, Gin,
// AddSub, Done, Tstep; instr_count when the macro
// CTRL_INSTR_COUNT_EN is defined.
module controle_multiciclo
  import ctrl_defs::*;
#(
  parameter int N_REGS   = 8,
  parameter int REG_BITS = 3,
  parameter int OP_BITS  = 3
) (
  input  logic                          Clock,
  input  logic                          Resetn,
  input  logic                          Run,
  input  logic [OP_BITS+2*REG_BITS-1:0] IR,
  input  logic                          G_nz,
  output logic                          IRin,
  output logic                          DINout,
  output logic                          Gout,
  output logic [N_REGS-1:0]             Rout,
  output logic [N_REGS-1:0]             Rin,
  output logic                          Ain,
  output logic                          Gin,
  output logic                          AddSub,
  output logic                          Done,
  output logic [1:0]                    Tstep
`ifdef CTRL_INSTR_COUNT_EN
  ,
  output logic [15:0]                   instr_count
`endif
);

  tstep_e tstep_q, tstep_d;

  logic [OP_BITS-1:0]  op;
  logic [REG_BITS-1:0] rx, ry;
  logic [N_REGS-1:0]   rx_oh, ry_oh;

  logic is_mv, is_mvi, is_alu, is_mvnz;
  logic rin_en, rout_rx, rout_ry;

  assign op = IR[IR_OP_LSB +: OP_BITS];
  assign rx = IR[IR_RX_LSB +: REG_BITS];
  assign ry = IR[IR_RY_LSB +: REG_BITS];

  assign is_mv   = (op == OP_MV);
  assign is_mvi  = (op == OP_MVI);
  assign is_alu  = (op == OP_ADD) || (op == OP_SUB);
  assign is_mvnz = (op == OP_MVNZ);

  dec3to8 #(
    .IN_W  (REG_BITS),
    .OUT_W (N_REGS)
  ) u_dec_rx (
    .a  (rx),
    .en (1'b1),
    .y  (rx_oh)
  );

  dec3to8 #(
    .IN_W  (REG_BITS),
    .OUT_W (N_REGS)
  ) u_dec_ry (
    .a  (ry),
    .en (1'b1),
    .y  (ry_oh)
  );

  always_ff @(posedge Clock) begin
    if (!Resetn) tstep_q <= T0;
    else         tstep_q <= tstep_d;
  end

  always_comb begin
    tstep_d = tstep_q;
    IRin    = 1'b0;
    DINout  = 1'b0;
    Gout    = 1'b0;
    Ain     = 1'b0;
    Gin     = 1'b0;
    AddSub  = 1'b0;
    Done    = 1'b0;
    rin_en  = 1'b0;
    rout_rx = 1'b0;
    rout_ry = 1'b0;
    unique case (tstep_q)
      T0: begin
        IRin    = Run;
        tstep_d = Run ? T1 : T0;
      end
      T1: begin
        tstep_d = T0;
        unique case (1'b1)
          is_mv: begin
            rout_ry = 1'b1;
            rin_en  = 1'b1;
            Done    = 1'b1;
          end
          is_mvi: begin
            DINout = 1'b1;
            rin_en = 1'b1;
            Done   = 1'b1;
          end
          is_alu: begin
            rout_rx = 1'b1;
            Ain     = 1'b1;
            tstep_d = T2;
          end
          is_mvnz: begin
            rout_ry = 1'b1;
            rin_en  = G_nz;
            Done    = 1'b1;
          end
          default: Done = 1'b1;
        endcase
      end
      T2: begin
        // T2 with a non-ALU opcode only happens if IR
        // changed underneath us; finish cleanly.
        if (is_alu) begin
          rout_ry = 1'b1;
          Gin     = 1'b1;
          AddSub  = (op == OP_SUB);
          tstep_d = T3;
        end else begin
          Done    = 1'b1;
          tstep_d = T0;
        end
      end
      T3: begin
        Done    = 1'b1;
        tstep_d = T0;
        if (is_alu) begin
          Gout   = 1'b1;
          rin_en = 1'b1;
        end
      end
      default: tstep_d = T0;
    endcase
  end

  assign Rin   = rin_en ? rx_oh : '0;
  assign Rout  = rout_rx ? rx_oh :
                 rout_ry ? ry_oh : '0;
  assign Tstep = tstep_q;

`ifdef CTRL_INSTR_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + (Done ? 16'd1 : 16'd0);
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign instr_count = cnt_q;
`endif

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed self-checking bench for controle_multiciclo.
// Outputs sampled 2 time units after each rising edge.
module tb_controle_multiciclo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [8:0] ir;
  logic       g_nz;
  logic       irin, dinout, gout, ain, gin, addsub, done;
  logic [7:0] rout, rin;
  logic [1:0] tstep;
`ifdef CTRL_INSTR_COUNT_EN
  logic [15:0] icnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [24:0] obs;

  always #5 clk = ~clk;

  controle_multiciclo dut (
    .Clock  (clk),
    .Resetn (rst_n),
    .Run    (run),
    .IR     (ir),
    .G_nz   (g_nz),
    .IRin   (irin),
    .DINout (dinout),
    .Gout   (gout),
    .Rout   (rout),
    .Rin    (rin),
    .Ain    (ain),
    .Gin    (gin),
    .AddSub (addsub),
    .Done   (done),
    .Tstep  (tstep)
`ifdef CTRL_INSTR_COUNT_EN
    ,
    .instr_count (icnt)
`endif
  );

  assign obs = {irin, dinout, gout, rout, rin,
                ain, gin, addsub, done, tstep};

  function automatic logic [24:0] ev(
    input logic       i_ir,
    input logic       i_di,
    input logic       i_go,
    input logic [7:0] i_ro,
    input logic [7:0] i_ri,
    input logic       i_a,
    input logic       i_g,
    input logic       i_s,
    input logic       i_d,
    input logic [1:0] i_t
  );
    return {i_ir, i_di, i_go, i_ro, i_ri,
            i_a, i_g, i_s, i_d, i_t};
  endfunction

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [24:0] e);
    #1;
    n_cmp++;
    assert (obs === e) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h",
             tag, obs, e);
    end
  endtask

`ifdef CTRL_INSTR_COUNT_EN
  task automatic chk_cnt(input string tag,
                         input logic [15:0] e);
    #1;
    n_cmp++;
    assert (icnt === e) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d",
             tag, icnt, e);
    end
  endtask
`endif

  localparam logic [24:0] ZERO = '0;

  initial begin
    rst_n = 1'b0;
    run   = 1'b0;
    ir    = '0;
    g_nz  = 1'b0;
    go();
    go();
    rst_n = 1'b1;
    chk("reset", ZERO);
`ifdef CTRL_INSTR_COUNT_EN
    chk_cnt("cnt_reset", 16'd0);
`endif
    for (int i = 0; i < 3; i++) begin
      go();
      chk("idle", ZERO);
    end

    // mv R0,R1
    ir  = 9'b000_000_001;
    run = 1'b1;
    chk("mv_t0", ev(1,0,0,8'h00,8'h00,0,0,0,0,2'd0));
    go();
    run = 1'b0;
    chk("mv_t1", ev(0,0,0,8'h02,8'h01,0,0,0,1,2'd1));
    go();
    chk("mv_end", ZERO);

    // mvi R0
    ir  = 9'b001_000_001;
    run = 1'b1;
    chk("mvi_t0", ev(1,0,0,8'h00,8'h00,0,0,0,0,2'd0));
    go();
    run = 1'b0;
    chk("mvi_t1", ev(0,1,0,8'h00,8'h01,0,0,0,1,2'd1));
    go();

    // sub R1,R0 with Run dropped after fetch
    ir  = 9'b011_001_000;
    run = 1'b1;
    go();
    run = 1'b0;
    chk("sub_t1", ev(0,0,0,8'h02,8'h00,1,0,0,0,2'd1));
    go();
    chk("sub_t2", ev(0,0,0,8'h01,8'h00,0,1,1,0,2'd2));
    go();
    chk("sub_t3", ev(0,0,1,8'h00,8'h02,0,0,0,1,2'd3));
    go();
    chk("sub_end", ZERO);

    // add R2,R2
    ir  = 9'b010_010_010;
    run = 1'b1;
    go();
    run = 1'b0;
    chk("add_t1", ev(0,0,0,8'h04,8'h00,1,0,0,0,2'd1));
    go();
    chk("add_t2", ev(0,0,0,8'h04,8'h00,0,1,0,0,2'd2));
    go();
    chk("add_t3", ev(0,0,1,8'h00,8'h04,0,0,0,1,2'd3));
    go();

    // mvnz R0,R1 with G_nz=0 then 1
    ir  = 9'b100_000_001;
    run = 1'b1;
    go();
    run = 1'b0;
    chk("mvnz0", ev(0,0,0,8'h02,8'h00,0,0,0,1,2'd1));
    go();
    g_nz = 1'b1;
    run  = 1'b1;
    go();
    run = 1'b0;
    chk("mvnz1", ev(0,0,0,8'h02,8'h01,0,0,0,1,2'd1));
    go();
    g_nz = 1'b0;

    // illegal opcode 101
    ir  = 9'b101_011_100;
    run = 1'b1;
    go();
    run = 1'b0;
    chk("ill_t1", ev(0,0,0,8'h00,8'h00,0,0,0,1,2'd1));
    go();
    chk("ill_end", ZERO);

    // IR forced to mv while in T3
    ir  = 9'b010_001_010;
    run = 1'b1;
    go();
    run = 1'b0;
    go();
    go();
    ir = 9'b000_001_010;
    chk("forced_t3", ev(0,0,0,8'h00,8'h00,0,0,0,1,2'd3));
    go();
    chk("forced_end", ZERO);

    // reset during add T2
    ir  = 9'b010_011_100;
    run = 1'b1;
    go();
    run = 1'b0;
    go();
    chk("rst_t2", ev(0,0,0,8'h10,8'h00,0,1,0,0,2'd2));
    rst_n = 1'b0;
    go();
    rst_n = 1'b1;
    chk("rst_mid", ZERO);
    go();
    chk("rst_after", ZERO);

    // back-to-back mv, sub, illegal 111
    rst_n = 1'b0;
    go();
    rst_n = 1'b1;
`ifdef CTRL_INSTR_COUNT_EN
    chk_cnt("cnt_clr", 16'd0);
`endif
    run = 1'b1;
    ir  = 9'b000_000_001;
    go();
    chk("b2b_mv", ev(0,0,0,8'h02,8'h01,0,0,0,1,2'd1));
    go();
    ir = 9'b011_001_000;
    chk("b2b_fetch", ev(1,0,0,8'h00,8'h00,0,0,0,0,2'd0));
    go();
    chk("b2b_sub_t1", ev(0,0,0,8'h02,8'h00,1,0,0,0,2'd1));
    go();
    go();
    chk("b2b_sub_t3", ev(0,0,1,8'h00,8'h02,0,0,0,1,2'd3));
    go();
    ir = 9'b111_000_000;
    chk("b2b_fetch2", ev(1,0,0,8'h00,8'h00,0,0,0,0,2'd0));
    go();
    run = 1'b0;
    chk("b2b_ill", ev(0,0,0,8'h00,8'h00,0,0,0,1,2'd1));
    go();
    chk("b2b_end", ZERO);
`ifdef CTRL_INSTR_COUNT_EN
    chk_cnt("cnt_three", 16'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
